// File: rtl/mc10_cass_pkg.sv
// mc10_cass_pkg: shared player state encoding and FSK half-period helper
package mc10_cass_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HI, LO} state_t;

    function automatic int half_period(input int clk_hz, input int freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

endpackage

// File: rtl/mc10_cass_fifo.sv
// mc10_cass_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop
module mc10_cass_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // pointers carry a wrap bit so full and empty are distinguishable
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk_sys) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mc10_cass_player.sv
// mc10_cass_player: buffers tape-image bytes and replays them as MC-10 FSK on cin
module mc10_cass_player
    import mc10_cass_pkg::*;
#(
    parameter int CLK_HZ     = 28636360,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        play,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_last,
    output logic        cin,
    output logic        busy,
    output logic        underrun,
    output logic        done,
    output logic [15:0] byte_cnt
);
    localparam int HALF_1 = half_period(CLK_HZ, 2400);
    localparam int HALF_0 = half_period(CLK_HZ, 1200);
    localparam int CW     = $clog2(HALF_0);
    localparam logic [CW-1:0] H1M = CW'(HALF_1 - 1);
    localparam logic [CW-1:0] H0M = CW'(HALF_0 - 1);

    state_t        state;
    logic [7:0]    sr;
    logic          last_f;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [8:0]    f_data;
    logic          f_full;
    logic          f_empty;
    logic          half_end;
    logic          next_ok;
    logic          pop;

    assign half_end = cnt == '0;
    // a following byte is chained straight out of LO so bytes play gapless
    assign next_ok  = state == LO && half_end && idx == 3'd7 && !last_f && play && !f_empty;
    assign pop      = state == LOAD || next_ok;
    assign wr_ready = !f_full;
    assign cin      = state == HI;
    assign busy     = state != IDLE;

    mc10_cass_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (wr_valid && !f_full),
        .wr_data ({wr_last, wr_data}),
        .pop     (pop),
        .rd_data (f_data),
        .full    (f_full),
        .empty   (f_empty)
    );

    // player FSM: each bit is one HI half-period followed by one LO half-period
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sr       <= '0;
            last_f   <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            underrun <= 1'b0;
            done     <= 1'b0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (play && !f_empty && !done) state <= LOAD;
                LOAD: begin
                    sr     <= f_data[7:0];
                    last_f <= f_data[8];
                    idx    <= '0;
                    cnt    <= f_data[0] ? H1M : H0M;
                    state  <= HI;
                end
                HI: begin
                    cnt   <= half_end ? (sr[0] ? H1M : H0M) : cnt - 1'b1;
                    state <= half_end ? LO : HI;
                end
                default: begin
                    if (!half_end) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx != 3'd7) begin
                        sr    <= sr >> 1;
                        idx   <= idx + 3'd1;
                        cnt   <= sr[1] ? H1M : H0M;
                        state <= HI;
                    end else begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (last_f) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (next_ok) begin
                            sr     <= f_data[7:0];
                            last_f <= f_data[8];
                            idx    <= '0;
                            cnt    <= f_data[0] ? H1M : H0M;
                            state  <= HI;
                        end else begin
                            if (play) underrun <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
